// File: rtl/alu_core_if.sv
// ALU stimulus/response bus between the stimulus driver and the ALU responder.
// master: drives CE/MODE/CMD/OPA/OPB/CIN/INP_VALID, observes RES and flags.
// slave : the ALU; samples the request side and drives RES/COUT/OFLOW/G/L/E/ERR.
interface alu_core_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic                  CE;
    logic                  MODE;
    logic [3:0]            CMD;
    logic [DATA_WIDTH-1:0] OPA;
    logic [DATA_WIDTH-1:0] OPB;
    logic                  CIN;
    logic [1:0]            INP_VALID;
    logic [DATA_WIDTH+1:0] RES;
    logic                  COUT;
    logic                  OFLOW;
    logic                  G;
    logic                  L;
    logic                  E;
    logic                  ERR;

    modport master (
        output CE, MODE, CMD, OPA, OPB, CIN, INP_VALID,
        input  RES, COUT, OFLOW, G, L, E, ERR
    );

    modport slave (
        input  CE, MODE, CMD, OPA, OPB, CIN, INP_VALID,
        output RES, COUT, OFLOW, G, L, E, ERR
    );
endinterface

// File: rtl/alu_core.sv
// ALU responder: collects operands (possibly on different cycles), computes
// arithmetic/logical/compare/multiply results and registers RES plus flags.
// Ports: clk, rst (sync, active-high), bus (alu_core_if.slave).
module alu_core #(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned WAIT_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    alu_core_if.slave  bus
);
    localparam int unsigned RW = DATA_WIDTH + 2;
    localparam int unsigned SW = $clog2(DATA_WIDTH);
    localparam int unsigned CW = $clog2(WAIT_CYCLES + 1);
    // Output word layout: {err, g, l, e, oflow, cout, res}
    localparam int unsigned OW = RW + 6;
    localparam logic [OW-1:0] ERR_OUT = {1'b1, {(OW-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, WAIT, MUL, OUT} state_t;

    // Operand class: 2'b01 A only, 2'b10 B only, 2'b11 both.
    function automatic logic [1:0] op_class(input logic mode, input logic [3:0] cmd);
        logic [1:0] c;
        c = 2'b11;
        if (mode) begin
            if (cmd == 4'd4 || cmd == 4'd5)      c = 2'b01;
            else if (cmd == 4'd6 || cmd == 4'd7) c = 2'b10;
        end else begin
            if (cmd == 4'd6 || cmd == 4'd8 || cmd == 4'd9)        c = 2'b01;
            else if (cmd == 4'd7 || cmd == 4'd10 || cmd == 4'd11) c = 2'b10;
        end
        return c;
    endfunction

    function automatic logic op_legal(input logic mode, input logic [3:0] cmd);
        return mode ? (cmd <= 4'd10) : (cmd <= 4'd13);
    endfunction

    function automatic logic op_mul(input logic mode, input logic [3:0] cmd);
        return mode && (cmd == 4'd9 || cmd == 4'd10);
    endfunction

    // Result and flags for one operation; arithmetic is carried out at RES width.
    function automatic logic [OW-1:0] compute(
        input logic                  mode,
        input logic [3:0]            cmd,
        input logic [DATA_WIDTH-1:0] a,
        input logic [DATA_WIDTH-1:0] b,
        input logic                  cin
    );
        logic [RW-1:0]           ax, bx, cx, res;
        logic [DATA_WIDTH-1:0]   lg;
        logic [2*DATA_WIDTH-1:0] rr;
        logic [SW-1:0]           amt;
        logic                    cout, oflow, g, l, e, err;
        ax = RW'(a);
        bx = RW'(b);
        cx = RW'(cin);
        res = '0;
        lg = '0;
        rr = '0;
        amt = b[SW-1:0];
        cout = 1'b0;
        oflow = 1'b0;
        g = 1'b0;
        l = 1'b0;
        e = 1'b0;
        err = 1'b0;
        if (mode) begin
            case (cmd)
                4'd0:  begin res = ax + bx;               cout  = res[DATA_WIDTH]; end
                4'd1:  begin res = ax - bx;               oflow = (ax < bx); end
                4'd2:  begin res = ax + bx + cx;          cout  = res[DATA_WIDTH]; end
                4'd3:  begin res = ax - bx - cx;          oflow = (ax < (bx + cx)); end
                4'd4:  begin res = ax + RW'(1);           cout  = res[DATA_WIDTH]; end
                4'd5:  begin res = ax - RW'(1);           oflow = (a == '0); end
                4'd6:  begin res = bx + RW'(1);           cout  = res[DATA_WIDTH]; end
                4'd7:  begin res = bx - RW'(1);           oflow = (b == '0); end
                4'd8:  begin g = (a > b); l = (a < b); e = (a == b); end
                4'd9:  res = (ax + RW'(1)) * (bx + RW'(1));
                4'd10: res = RW'({a[DATA_WIDTH-2:0], 1'b0}) * bx;
                default: err = 1'b1;
            endcase
        end else begin
            case (cmd)
                4'd0:  lg = a & b;
                4'd1:  lg = ~(a & b);
                4'd2:  lg = a | b;
                4'd3:  lg = ~(a | b);
                4'd4:  lg = a ^ b;
                4'd5:  lg = ~(a ^ b);
                4'd6:  lg = ~a;
                4'd7:  lg = ~b;
                4'd8:  lg = a >> 1;
                4'd9:  lg = {a[DATA_WIDTH-2:0], 1'b0};
                4'd10: lg = b >> 1;
                4'd11: lg = {b[DATA_WIDTH-2:0], 1'b0};
                4'd12, 4'd13: begin
                    // Rotate amounts with any bit above the amount field + 1 set are rejected.
                    if ((b >> (SW + 1)) != '0) begin
                        err = 1'b1;
                    end else if (cmd == 4'd12) begin
                        rr = {a, a} << amt;
                        lg = rr[2*DATA_WIDTH-1:DATA_WIDTH];
                    end else begin
                        rr = {a, a} >> amt;
                        lg = rr[DATA_WIDTH-1:0];
                    end
                end
                default: err = 1'b1;
            endcase
            res = RW'(lg);
        end
        return {err, g, l, e, oflow, cout, res};
    endfunction

    state_t                state;
    logic [CW-1:0]         cnt;
    logic [DATA_WIDTH-1:0] a_q, b_q;
    logic [3:0]            cmd_q;
    logic                  mode_q, cin_q, have_a;
    logic [OW-1:0]         out_q;

    logic [1:0]            vld_c, need_c;
    logic                  legal_c, mul_c, deliver_c;
    logic [DATA_WIDTH-1:0] a_sel_c, b_sel_c;
    logic [OW-1:0]         now_out_c, wait_out_c, mul_out_c;

    assign vld_c      = bus.INP_VALID;
    assign need_c     = op_class(bus.MODE, bus.CMD);
    assign legal_c    = op_legal(bus.MODE, bus.CMD);
    assign mul_c      = op_mul(bus.MODE, bus.CMD);
    // In WAIT the latched operand is kept; the missing one comes from the bus.
    assign deliver_c  = have_a ? vld_c[1] : vld_c[0];
    assign a_sel_c    = have_a ? a_q : bus.OPA;
    assign b_sel_c    = have_a ? bus.OPB : b_q;
    assign now_out_c  = compute(bus.MODE, bus.CMD, bus.OPA, bus.OPB, bus.CIN);
    assign wait_out_c = compute(mode_q, cmd_q, a_sel_c, b_sel_c, cin_q);
    assign mul_out_c  = compute(mode_q, cmd_q, a_q, b_q, cin_q);

    // Operand collection FSM with registered result/flags; CE=0 freezes everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            a_q    <= '0;
            b_q    <= '0;
            cmd_q  <= '0;
            mode_q <= 1'b0;
            cin_q  <= 1'b0;
            have_a <= 1'b0;
            out_q  <= '0;
        end else if (bus.CE) begin
            case (state)
                IDLE, OUT: begin
                    state <= IDLE;
                    if (!legal_c || vld_c == 2'b00) begin
                        out_q <= ERR_OUT;
                    end else if (need_c != 2'b11) begin
                        out_q <= ((vld_c & need_c) != 2'b00) ? now_out_c : ERR_OUT;
                    end else if (vld_c == 2'b11) begin
                        if (mul_c) begin
                            a_q    <= bus.OPA;
                            b_q    <= bus.OPB;
                            cmd_q  <= bus.CMD;
                            mode_q <= bus.MODE;
                            cin_q  <= bus.CIN;
                            state  <= MUL;
                        end else begin
                            out_q <= now_out_c;
                        end
                    end else begin
                        a_q    <= bus.OPA;
                        b_q    <= bus.OPB;
                        cmd_q  <= bus.CMD;
                        mode_q <= bus.MODE;
                        cin_q  <= bus.CIN;
                        have_a <= vld_c[0];
                        cnt    <= '0;
                        state  <= WAIT;
                    end
                end
                WAIT: begin
                    if (deliver_c) begin
                        if (have_a) b_q <= bus.OPB;
                        else        a_q <= bus.OPA;
                        if (op_mul(mode_q, cmd_q)) begin
                            state <= MUL;
                        end else begin
                            out_q <= wait_out_c;
                            state <= IDLE;
                        end
                    end else if (cnt == CW'(WAIT_CYCLES - 1)) begin
                        out_q <= ERR_OUT;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                MUL: begin
                    out_q <= mul_out_c;
                    state <= OUT;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.RES   = out_q[RW-1:0];
    assign bus.COUT  = out_q[RW];
    assign bus.OFLOW = out_q[RW+1];
    assign bus.E     = out_q[RW+2];
    assign bus.L     = out_q[RW+3];
    assign bus.G     = out_q[RW+4];
    assign bus.ERR   = out_q[RW+5];
endmodule

// File: tb/tb_alu_core.sv
// Self-checking bench for alu_core: directed scenarios then randomized traffic,
// every cycle compared against a behavioural model built from integer arithmetic.
module tb_alu_core;
    typedef struct packed {
        logic [9:0] res;
        logic       cout;
        logic       oflow;
        logic       g;
        logic       l;
        logic       e;
        logic       err;
    } exp_t;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_pass;

    alu_core_if #(.DATA_WIDTH(8)) bus ();

    alu_core #(.DATA_WIDTH(8), .WAIT_CYCLES(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model state: what the outputs should be and what is pending.
    exp_t m_out;
    bit   m_waiting;
    bit   m_mul_busy;
    int   m_a, m_b, m_cin, m_mode, m_cmd, m_have_a, m_cnt;

    function automatic exp_t err_word();
        exp_t r;
        r = '0;
        r.err = 1'b1;
        return r;
    endfunction

    // 0 = illegal, 1 = A only, 2 = B only, 3 = both operands
    function automatic int operands(input int mode, input int cmd);
        if (mode == 1) begin
            if (cmd > 10) return 0;
            if (cmd == 4 || cmd == 5) return 1;
            if (cmd == 6 || cmd == 7) return 2;
            return 3;
        end
        if (cmd > 13) return 0;
        if (cmd == 6 || cmd == 8 || cmd == 9) return 1;
        if (cmd == 7 || cmd == 10 || cmd == 11) return 2;
        return 3;
    endfunction

    function automatic exp_t ref_result(input int mode, input int cmd, input int a,
                                        input int b, input int cin);
        exp_t r;
        int   t;
        int   k;
        r = '0;
        t = 0;
        if (mode == 1) begin
            case (cmd)
                0: begin t = a + b;       r.cout  = (t > 255); end
                1: begin t = a - b;       r.oflow = (t < 0); end
                2: begin t = a + b + cin; r.cout  = (t > 255); end
                3: begin t = a - b - cin; r.oflow = (t < 0); end
                4: begin t = a + 1;       r.cout  = (t > 255); end
                5: begin t = a - 1;       r.oflow = (t < 0); end
                6: begin t = b + 1;       r.cout  = (t > 255); end
                7: begin t = b - 1;       r.oflow = (t < 0); end
                8: begin r.g = (a > b); r.l = (a < b); r.e = (a == b); end
                9: t = (a + 1) * (b + 1);
                10: t = ((a * 2) % 256) * b;
                default: r.err = 1'b1;
            endcase
            r.res = 10'(t & 1023);
        end else begin
            case (cmd)
                0: t = a & b;
                1: t = 255 - (a & b);
                2: t = a | b;
                3: t = 255 - (a | b);
                4: t = a ^ b;
                5: t = 255 - (a ^ b);
                6: t = 255 - a;
                7: t = 255 - b;
                8: t = a / 2;
                9: t = (a * 2) % 256;
                10: t = b / 2;
                11: t = (b * 2) % 256;
                12, 13: begin
                    if (b >= 16) begin
                        r.err = 1'b1;
                    end else begin
                        k = b % 8;
                        if (cmd == 12) t = ((a << k) | (a >> (8 - k))) & 255;
                        else           t = ((a >> k) | (a << (8 - k))) & 255;
                    end
                end
                default: r.err = 1'b1;
            endcase
            r.res = 10'(t & 255);
        end
        return r;
    endfunction

    function automatic logic [15:0] observed();
        return {bus.RES, bus.COUT, bus.OFLOW, bus.G, bus.L, bus.E, bus.ERR};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_out      = '0;
        m_waiting  = 1'b0;
        m_mul_busy = 1'b0;
        m_cnt      = 0;
    endtask

    // One clock of the behavioural model, using the values on the bus at the edge.
    task automatic model_cycle(input int mode, input int cmd, input int a, input int b,
                               input int cin, input int vld);
        int need;
        if (m_mul_busy) begin
            m_out      = ref_result(m_mode, m_cmd, m_a, m_b, m_cin);
            m_mul_busy = 1'b0;
        end else if (m_waiting) begin
            if ((m_have_a == 1) ? (vld >= 2) : (vld % 2 == 1)) begin
                if (m_have_a == 1) m_b = b;
                else               m_a = a;
                m_waiting = 1'b0;
                if (m_mode == 1 && (m_cmd == 9 || m_cmd == 10)) m_mul_busy = 1'b1;
                else m_out = ref_result(m_mode, m_cmd, m_a, m_b, m_cin);
            end else begin
                m_cnt++;
                if (m_cnt == 16) begin
                    m_waiting = 1'b0;
                    m_out     = err_word();
                end
            end
        end else begin
            need = operands(mode, cmd);
            if (need == 0 || vld == 0) begin
                m_out = err_word();
            end else if (need == 1) begin
                m_out = (vld % 2 == 1) ? ref_result(mode, cmd, a, b, cin) : err_word();
            end else if (need == 2) begin
                m_out = (vld >= 2) ? ref_result(mode, cmd, a, b, cin) : err_word();
            end else begin
                m_a = a; m_b = b; m_cin = cin; m_mode = mode; m_cmd = cmd;
                if (vld == 3) begin
                    if (mode == 1 && (cmd == 9 || cmd == 10)) m_mul_busy = 1'b1;
                    else m_out = ref_result(mode, cmd, a, b, cin);
                end else begin
                    m_waiting = 1'b1;
                    m_have_a  = vld % 2;
                    m_cnt     = 0;
                end
            end
        end
    endtask

    task automatic step(input bit ce, input int mode, input int cmd, input int a,
                        input int b, input int cin, input int vld);
        bus.CE        = ce;
        bus.MODE      = 1'(mode);
        bus.CMD       = 4'(cmd);
        bus.OPA       = 8'(a);
        bus.OPB       = 8'(b);
        bus.CIN       = 1'(cin);
        bus.INP_VALID = 2'(vld);
        @(posedge clk);
        if (ce) model_cycle(mode, cmd, a, b, cin, vld);
        #1;
        chk("model", 32'(observed()), 32'(m_out));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        model_reset();
        #1;
        rst = 1'b0;
        chk("reset_zero", 32'(observed()), 32'(0));
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        rst    = 1'b1;
        bus.CE = 1'b0; bus.MODE = 1'b0; bus.CMD = '0; bus.OPA = '0; bus.OPB = '0;
        bus.CIN = 1'b0; bus.INP_VALID = '0;
        model_reset();

        do_reset();

        // Arithmetic basics
        step(1, 1, 0, 8'hFF, 8'h01, 0, 3);
        chk("add_res", 32'(bus.RES), 32'h100);
        chk("add_cout", 32'(bus.COUT), 32'd1);
        chk("add_err", 32'(bus.ERR), 32'd0);
        step(1, 1, 1, 8'h00, 8'h01, 0, 3);
        chk("sub_res", 32'(bus.RES), 32'h3FF);
        chk("sub_oflow", 32'(bus.OFLOW), 32'd1);
        step(1, 1, 8, 5, 9, 0, 3);
        chk("cmp_lge", 32'({bus.L, bus.G, bus.E}), 32'b100);
        chk("cmp_res", 32'(bus.RES), 32'd0);

        // Multiply latency: held after one edge, result after two
        step(1, 1, 9, 3, 4, 0, 3);
        chk("mul_lat1", 32'(bus.RES), 32'd0);
        step(1, 1, 0, 8'hAA, 8'h55, 0, 3);
        chk("mul_inc", 32'(bus.RES), 32'd20);
        step(1, 1, 10, 8'h80, 2, 0, 3);
        step(1, 1, 0, 8'h11, 8'h22, 0, 3);
        chk("mul_shl", 32'(bus.RES), 32'd0);

        // Operand B arrives on the 5th waiting cycle; CMD/MODE changes ignored
        step(1, 1, 0, 7, 0, 0, 1);
        for (int i = 0; i < 4; i++) step(1, 0, 3, 0, 0, 0, 0);
        step(1, 0, 1, 0, 5, 0, 2);
        chk("wait_res", 32'(bus.RES), 32'd12);
        chk("wait_err", 32'(bus.ERR), 32'd0);

        // Timeout after 16 non-delivering cycles; CE=0 cycles do not count
        step(1, 1, 0, 7, 0, 0, 1);
        for (int i = 0; i < 8; i++) step(1, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 9, 0, 2);
        for (int i = 0; i < 7; i++) step(1, 1, 0, 0, 0, 0, 0);
        chk("wait_15_err", 32'(bus.ERR), 32'd0);
        chk("wait_15_res", 32'(bus.RES), 32'd12);
        step(1, 1, 0, 0, 0, 0, 0);
        chk("timeout_err", 32'(bus.ERR), 32'd1);
        chk("timeout_res", 32'(bus.RES), 32'd0);

        // Error entry cases
        step(1, 1, 0, 1, 1, 0, 0);
        chk("vld00_err", 32'(bus.ERR), 32'd1);
        step(1, 1, 6, 0, 8'hFF, 0, 2);
        chk("inc_b_res", 32'(bus.RES), 32'h100);
        step(1, 1, 4, 0, 0, 0, 2);
        chk("inc_a_nop", 32'(bus.ERR), 32'd1);
        step(1, 1, 12, 1, 1, 0, 3);
        chk("bad_cmd", 32'(bus.ERR), 32'd1);

        // Rotates
        step(1, 0, 12, 8'h81, 1, 0, 3);
        chk("rol_res", 32'(bus.RES), 32'h03);
        step(1, 0, 12, 8'h81, 8'h10, 0, 3);
        chk("rol_err", 32'(bus.ERR), 32'd1);
        chk("rol_err_res", 32'(bus.RES), 32'd0);
        step(1, 0, 13, 8'h81, 2, 0, 3);
        chk("ror_res", 32'(bus.RES), 32'h60);

        // Reset during WAIT: the pending operand must be forgotten
        step(1, 1, 0, 1, 2, 0, 3);
        step(1, 1, 0, 7, 0, 0, 1);
        do_reset();
        step(1, 1, 0, 0, 5, 0, 2);
        chk("rst_wait_nolate", 32'(bus.RES), 32'd0);
        do_reset();

        // Reset during MUL: no late product
        step(1, 1, 9, 3, 4, 0, 3);
        do_reset();
        step(1, 1, 0, 1, 1, 0, 3);
        chk("rst_mul_nolate", 32'(bus.RES), 32'd2);

        // CE=0 with changing inputs holds outputs
        for (int i = 0; i < 4; i++)
            step(0, int'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
                 int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                 int'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
        chk("ce0_hold", 32'(bus.RES), 32'd2);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 63) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(0, 9) != 0, int'($urandom_range(0, 1)),
                     int'($urandom_range(0, 15)), int'($urandom_range(0, 255)),
                     ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15))
                                                 : int'($urandom_range(0, 255)),
                     int'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/alu_core.md
Name: alu_core

Overview:
- Synthesizable ALU DUT: the responder at the far end of the ALU stimulus interface.
- Samples CE/MODE/CMD/OPA/OPB/CIN/INP_VALID each clk.
- Collects operands that may arrive on different cycles, computes arithmetic/logical/compare/multiply results, and drives registered RES plus flags back to the monitor side.
- Instantiated under the testbench top, wired one-to-one to the interface signals.

Parameters:
- DATA_WIDTH, 8, operand width. RES is DATA_WIDTH+2 bits.
- WAIT_CYCLES, 16, maximum cycles to wait for a missing second operand.

Ports:
- clk  input  1  clock, all logic on posedge
- rst  input  1  synchronous, active-high reset
- CE  input  1  clock enable; when 0, no sampling and all outputs hold
- MODE  input  1  1 = arithmetic, 0 = logical
- CMD  input  4  operation code
- OPA  input  DATA_WIDTH  operand A
- OPB  input  DATA_WIDTH  operand B
- CIN  input  1  carry in
- INP_VALID  input  2  bit0 = OPA valid, bit1 = OPB valid
- RES  output  DATA_WIDTH+2  result
- COUT  output  1  carry out
- OFLOW  output  1  borrow/underflow
- G, L, E  output  1 each  compare A>B, A<B, A==B
- ERR  output  1  error

Behaviour:
- Reset: sampled at posedge while rst=1. All outputs go to 0, FSM goes to IDLE, wait counter and latched operands clear. rst overrides CE and aborts any WAIT or multiply in flight; no result is emitted for an aborted op.
- Arithmetic ops (MODE=1), results zero-extended into RES:
  - 0 ADD A+B; 1 SUB A-B; 2 ADD_CIN A+B+CIN; 3 SUB_CIN A-B-CIN
  - 4 INC_A; 5 DEC_A; 6 INC_B; 7 DEC_B
  - 8 CMP; 9 MUL_INC (A+1)*(B+1); 10 MUL_SHL (A<<1, truncated to DATA_WIDTH)*B
  - Products are truncated to DATA_WIDTH+2 bits.
- Logical ops (MODE=0), result in RES[DATA_WIDTH-1:0], upper bits 0:
  - 0 AND; 1 NAND; 2 OR; 3 NOR; 4 XOR; 5 XNOR
  - 6 NOT_A; 7 NOT_B; 8 SHR1_A; 9 SHL1_A; 10 SHR1_B; 11 SHL1_B
  - 12 ROL A by B; 13 ROR A by B
- Rotates: amount is OPB[$clog2(DATA_WIDTH)-1:0]. If OPB[DATA_WIDTH-1:$clog2(DATA_WIDTH)+1] != 0, then ERR=1 and RES=0.
- Any other CMD/MODE combination: ERR=1, RES=0.
- Flags:
  - COUT = carry of ADD/ADD_CIN/INC.
  - OFLOW = borrow of SUB/SUB_CIN/DEC (e.g. 0-1).
  - CMP drives G/L/E with RES=0.
  - Flags not defined for the current op are driven 0.
- Operand class per op: A-only (INC_A, DEC_A, NOT_A, SHx_A), B-only (INC_B, DEC_B, NOT_B, SHx_B), or both (all others).
- FSM states: IDLE, WAIT, MUL, OUT.
- IDLE, CE=1:
  - Required operands all valid: single-cycle ops register their result the next posedge (latency 1). Multiply ops go to MUL, and the result appears 2 posedges after sampling (latency 2).
  - Two-operand op with exactly one operand valid: latch that operand, CMD, MODE and CIN, go to WAIT, counter=0.
  - INP_VALID=00, or a single-operand op lacking its operand: ERR=1 next cycle.
- WAIT (while CE=1):
  - Each posedge where the missing bit is valid: latch the missing operand (the originally latched operand is kept) and compute with latency as in IDLE.
  - Counter increments on each posedge that does not deliver the operand. After WAIT_CYCLES such cycles, ERR=1 and RES=0 next cycle, return to IDLE.
  - CE=0 in WAIT freezes the counter.
  - CMD/MODE changes during WAIT are ignored.
- A new result replaces the previous outputs. Outputs are otherwise held, never auto-cleared.
- Back-to-back: after a single-cycle op the block accepts a new op every cycle. During MUL, inputs are not sampled.

Test Plan:
- MODE=1 CMD=0, OPA=8'hFF OPB=8'h01 INP_VALID=3 -> next cycle RES=10'h100, COUT=1, ERR=0.
- MODE=1 CMD=1, OPA=8'h00 OPB=8'h01 -> RES=10'h3FF (low 8 bits 8'hFF), OFLOW=1. Then CMD=8, OPA=5 OPB=9 -> L=1, G=0, E=0, RES=0.
- MODE=1 CMD=9, OPA=3 OPB=4 -> RES=20 exactly 2 cycles after sampling. CMD=10, OPA=8'h80 OPB=2 -> RES=0 (A<<1 truncates to 0).
- INP_VALID=01 OPA=7 CMD=0 MODE=1, then INP_VALID=10 OPB=5 on cycle 5 -> RES=12, ERR=0. Repeat with OPB never valid -> ERR=1 after exactly 16 waiting cycles.
- MODE=0 CMD=12, OPA=8'h81 OPB=1 -> RES=8'h03. OPB=8'h10 -> ERR=1, RES=0.
- rst asserted during WAIT and during MUL -> all outputs 0 next cycle, no late result. CE=0 with changing inputs -> outputs unchanged.
